alu_share_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters, e.g. the main datapath (port 0) and a debug/test-access unit (port 1).
- Arbitrates round-robin and registers the winner's operands onto the ALU inputs.
- Waits a configurable settle time, then captures result and zero flag.
- Returns them to the winning requester over a valid/ready response handshake.

---
 rtl/alu_share_arbiter_if.sv | 59 +++++
 rtl/alu_share_arbiter.sv | 161 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
// Bundles everything between the arbiter and its surroundings except clock
// and reset:
//   - two request ports (Valid/Ready plus A, B, Imm, SrcB, Op)
//   - two response ports (Valid/Ready) and the shared RspResult/RspZero
//   - the registered ALU operand bus (AluA/AluB/AluImm/AluSrcB/AluOp) and
//     the ALU's answer (AluResult/AluZero)
//   - status: Busy, GrantId
// Modport slave is the arbiter's view; modport master is the view of
// everything around it (requesters, responders and the ALU itself).
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             Req0Valid;
    logic             Req1Valid;
    logic             Req0Ready;
    logic             Req1Ready;
    logic [WIDTH-1:0] Req0A;
    logic [WIDTH-1:0] Req1A;
    logic [WIDTH-1:0] Req0B;
    logic [WIDTH-1:0] Req1B;
    logic [WIDTH-1:0] Req0Imm;
    logic [WIDTH-1:0] Req1Imm;
    logic             Req0SrcB;
    logic             Req1SrcB;
    logic [2:0]       Req0Op;
    logic [2:0]       Req1Op;
    logic             Rsp0Valid;
    logic             Rsp1Valid;
    logic             Rsp0Ready;
    logic             Rsp1Ready;
    logic [WIDTH-1:0] RspResult;
    logic             RspZero;
    logic [WIDTH-1:0] AluA;
    logic [WIDTH-1:0] AluB;
    logic [WIDTH-1:0] AluImm;
    logic             AluSrcB;
    logic [2:0]       AluOp;
    logic [WIDTH-1:0] AluResult;
    logic             AluZero;
    logic             Busy;
    logic             GrantId;

    modport slave (
        input  Req0Valid, Req1Valid, Req0A, Req1A, Req0B, Req1B,
               Req0Imm, Req1Imm, Req0SrcB, Req1SrcB, Req0Op, Req1Op,
               Rsp0Ready, Rsp1Ready, AluResult, AluZero,
        output Req0Ready, Req1Ready, Rsp0Valid, Rsp1Valid, RspResult, RspZero,
               AluA, AluB, AluImm, AluSrcB, AluOp, Busy, GrantId
    );

    modport master (
        output Req0Valid, Req1Valid, Req0A, Req1A, Req0B, Req1B,
               Req0Imm, Req1Imm, Req0SrcB, Req1SrcB, Req0Op, Req1Op,
               Rsp0Ready, Rsp1Ready, AluResult, AluZero,
        input  Req0Ready, Req1Ready, Rsp0Valid, Rsp1Valid, RspResult, RspZero,
               AluA, AluB, AluImm, AluSrcB, AluOp, Busy, GrantId
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational ALU between two requesters. A round-robin winner
// is accepted in IDLE, its operands are registered onto the ALU bus, the
// result is sampled after LATENCY cycles and returned on the winner's
// response handshake. One operation in flight at a time.
// Ports:
//   CLK    - clock, all state changes on the rising edge
//   Reset  - synchronous active-high reset
//   bus    - alu_share_arbiter_if.slave (requests, responses, ALU bus, status)
// Parameters:
//   LATENCY - cycles the ALU inputs are held before sampling (1..15)
//   WIDTH   - operand/result width (must match the interface)
module alu_share_arbiter #(
    parameter int LATENCY = 1,
    parameter int WIDTH   = 32
) (
    input logic                 CLK,
    input logic                 Reset,
    alu_share_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_q, grant_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [WIDTH-1:0] alu_imm_q, alu_imm_d;
    logic             alu_srcb_q, alu_srcb_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             winner_s;
    logic             accept_s;
    logic             rsp_ready_s;

    // Round-robin pick: on a tie the port that did not win last time goes.
    always_comb begin
        winner_s = 1'b0;
        if (bus.Req0Valid && bus.Req1Valid) begin
            winner_s = ~last_grant_q;
        end else if (bus.Req1Valid) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    assign accept_s    = (state_q == IDLE) && (bus.Req0Valid || bus.Req1Valid);
    // Only the granted response port can complete the operation.
    assign rsp_ready_s = grant_q ? bus.Rsp1Ready : bus.Rsp0Ready;

    // Next-state and datapath register updates.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_imm_d    = alu_imm_q;
        alu_srcb_d   = alu_srcb_q;
        alu_op_d     = alu_op_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    grant_d = winner_s;
                    cnt_d   = 4'(LATENCY);
                    state_d = EXEC;
                    if (winner_s) begin
                        alu_a_d    = bus.Req1A;
                        alu_b_d    = bus.Req1B;
                        alu_imm_d  = bus.Req1Imm;
                        alu_srcb_d = bus.Req1SrcB;
                        alu_op_d   = bus.Req1Op;
                    end else begin
                        alu_a_d    = bus.Req0A;
                        alu_b_d    = bus.Req0B;
                        alu_imm_d  = bus.Req0Imm;
                        alu_srcb_d = bus.Req0SrcB;
                        alu_op_d   = bus.Req0Op;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 4'd1;
                // Counter value 1 marks the LATENCY-th edge after accept.
                if (cnt_q == 4'd1) begin
                    rsp_result_d = bus.AluResult;
                    rsp_zero_d   = bus.AluZero;
                    state_d      = RESP;
                end else begin
                    state_d = EXEC;
                end
            end
            RESP: begin
                if (rsp_ready_s) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_imm_q    <= '0;
            alu_srcb_q   <= 1'b0;
            alu_op_q     <= 3'd0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_imm_q    <= alu_imm_d;
            alu_srcb_q   <= alu_srcb_d;
            alu_op_q     <= alu_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign bus.Req0Ready = (state_q == IDLE) && !winner_s;
    assign bus.Req1Ready = (state_q == IDLE) &&  winner_s;
    assign bus.Rsp0Valid = (state_q == RESP) && !grant_q;
    assign bus.Rsp1Valid = (state_q == RESP) &&  grant_q;
    assign bus.RspResult = rsp_result_q;
    assign bus.RspZero   = rsp_zero_q;
    assign bus.AluA      = alu_a_q;
    assign bus.AluB      = alu_b_q;
    assign bus.AluImm    = alu_imm_q;
    assign bus.AluSrcB   = alu_srcb_q;
    assign bus.AluOp     = alu_op_q;
    assign bus.Busy      = (state_q != IDLE);
    assign bus.GrantId   = grant_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Drives two arbiter instances (LATENCY=1 and LATENCY=4) that share a clock
// and reset. A behavioural ALU closes the loop on each instance. Expected
// responses are queued when a request is accepted and popped when the
// response handshake is observed.
module tb_alu_share_arbiter;
    localparam int W = 32;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    alu_share_arbiter_if #(.WIDTH(W)) b1 ();
    alu_share_arbiter_if #(.WIDTH(W)) b4 ();

    alu_share_arbiter #(.LATENCY(1), .WIDTH(W)) u_dut1 (.CLK(CLK), .Reset(Reset), .bus(b1));
    alu_share_arbiter #(.LATENCY(4), .WIDTH(W)) u_dut4 (.CLK(CLK), .Reset(Reset), .bus(b4));

    // Behavioural ALU: returns {zero, result}; zero only reported for sub.
    function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] imm, input logic srcb,
                                         input logic [2:0] op);
        logic [W-1:0] rb;
        logic [W-1:0] r;
        rb = srcb ? imm : b;
        case (op)
            3'b000:  r = a + rb;
            3'b001:  r = a - rb;
            3'b010:  r = rb - a;
            3'b011:  r = a | rb;
            3'b100:  r = a & rb;
            3'b101:  r = a & ~rb;
            3'b110:  r = a ^ rb;
            default: r = ~(a ^ rb);
        endcase
        return {(op == 3'b001) && (r == '0), r};
    endfunction

    assign {b1.AluZero, b1.AluResult} = alu_f(b1.AluA, b1.AluB, b1.AluImm, b1.AluSrcB, b1.AluOp);
    assign {b4.AluZero, b4.AluResult} = alu_f(b4.AluA, b4.AluB, b4.AluImm, b4.AluSrcB, b4.AluOp);

    typedef struct {
        logic         port;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] imm;
        logic         srcb;
        logic [2:0]   op;
        logic [W-1:0] exp_res;
        logic         exp_zero;
    } vec_t;

    typedef struct {
        logic         port;
        logic [W-1:0] res;
        logic         zero;
    } sb_t;

    vec_t vecs[10];
    sb_t  sb[$];
    int   n_cmp  = 0;
    int   n_miss = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic sb_pop(input string nm, input logic port, input logic [W-1:0] res,
                          input logic zero);
        sb_t s;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            s = sb.pop_front();
            chk({nm, "_port"}, port, s.port);
            chk({nm, "_result"}, res, s.res);
            chk({nm, "_zero"}, zero, s.zero);
        end
    endtask

    task automatic clear_inputs();
        b1.Req0Valid = 1'b0; b1.Req1Valid = 1'b0; b4.Req0Valid = 1'b0; b4.Req1Valid = 1'b0;
        b1.Req0A = '0; b1.Req0B = '0; b1.Req0Imm = '0; b1.Req0SrcB = 1'b0; b1.Req0Op = 3'd0;
        b1.Req1A = '0; b1.Req1B = '0; b1.Req1Imm = '0; b1.Req1SrcB = 1'b0; b1.Req1Op = 3'd0;
        b4.Req0A = '0; b4.Req0B = '0; b4.Req0Imm = '0; b4.Req0SrcB = 1'b0; b4.Req0Op = 3'd0;
        b4.Req1A = '0; b4.Req1B = '0; b4.Req1Imm = '0; b4.Req1SrcB = 1'b0; b4.Req1Op = 3'd0;
        b1.Rsp0Ready = 1'b1; b1.Rsp1Ready = 1'b1; b4.Rsp0Ready = 1'b1; b4.Rsp1Ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset = 1'b1;
        clear_inputs();
        @(posedge CLK);
        @(posedge CLK);
        #1 Reset = 1'b0;
    endtask

    task automatic drive1(input vec_t v);
        if (v.port) begin
            b1.Req1Valid = 1'b1; b1.Req1A = v.a; b1.Req1B = v.b;
            b1.Req1Imm = v.imm; b1.Req1SrcB = v.srcb; b1.Req1Op = v.op;
        end else begin
            b1.Req0Valid = 1'b1; b1.Req0A = v.a; b1.Req0B = v.b;
            b1.Req0Imm = v.imm; b1.Req0SrcB = v.srcb; b1.Req0Op = v.op;
        end
    endtask

    // One complete operation on the LATENCY=1 instance.
    task automatic run_vec1(input int idx, input vec_t v);
        int  k;
        int  edges;
        logic rv;
        @(negedge CLK);
        drive1(v);
        #1;
        k = 0;
        while (!(v.port ? b1.Req1Ready : b1.Req0Ready) && k < 20) begin
            @(negedge CLK); #1; k++;
        end
        chk($sformatf("v%0d_req_ready", idx), v.port ? b1.Req1Ready : b1.Req0Ready, 32'd1);
        chk($sformatf("v%0d_other_ready", idx), v.port ? b1.Req0Ready : b1.Req1Ready, 32'd0);
        sb.push_back('{v.port, v.exp_res, v.exp_zero});
        @(posedge CLK);
        #1;
        b1.Req0Valid = 1'b0; b1.Req1Valid = 1'b0;
        b1.Req0A = $urandom; b1.Req1A = $urandom; b1.Req0B = $urandom; b1.Req1B = $urandom;
        edges = 0;
        rv = 1'b0;
        while (!rv && edges < 20) begin
            @(posedge CLK); #1; edges++;
            rv = v.port ? b1.Rsp1Valid : b1.Rsp0Valid;
        end
        chk($sformatf("v%0d_latency", idx), edges, 32'd1);
        chk($sformatf("v%0d_other_rsp", idx), v.port ? b1.Rsp0Valid : b1.Rsp1Valid, 32'd0);
        chk($sformatf("v%0d_grant", idx), b1.GrantId, v.port);
        sb_pop($sformatf("v%0d", idx), b1.Rsp1Valid, b1.RspResult, b1.RspZero);
        @(posedge CLK); #1;
        chk($sformatf("v%0d_idle", idx), b1.Busy, 32'd0);
    endtask

    initial begin
        int  edges;
        int  n_acc;
        logic g;
        logic seen;
        vecs[0] = '{1'b0, 32'd5,         32'd3,         32'd0,         1'b0, 3'b000, 32'd8,         1'b0};
        vecs[1] = '{1'b1, 32'd7,         32'd0,         32'd7,         1'b1, 3'b001, 32'd0,         1'b1};
        vecs[2] = '{1'b0, 32'd10,        32'd3,         32'd0,         1'b0, 3'b010, 32'hFFFFFFF9,  1'b0};
        vecs[3] = '{1'b1, 32'h000000F0,  32'h0000000F,  32'd0,         1'b0, 3'b011, 32'h000000FF,  1'b0};
        vecs[4] = '{1'b0, 32'hFF00FF00,  32'd0,         32'h0FF00FF0,  1'b1, 3'b100, 32'h0F000F00,  1'b0};
        vecs[5] = '{1'b1, 32'hFFFF0000,  32'h0F0F0F0F,  32'd0,         1'b0, 3'b101, 32'hF0F00000,  1'b0};
        vecs[6] = '{1'b0, 32'h12345678,  32'h12345678,  32'd0,         1'b0, 3'b110, 32'h00000000,  1'b0};
        vecs[7] = '{1'b1, 32'd0,         32'd0,         32'd0,         1'b0, 3'b111, 32'hFFFFFFFF,  1'b0};
        vecs[8] = '{1'b0, 32'd9,         32'd100,       32'd9,         1'b1, 3'b001, 32'd0,         1'b1};
        vecs[9] = '{1'b1, 32'd3,         32'd5,         32'd100,       1'b0, 3'b000, 32'd8,         1'b0};

        // Power-up reset values.
        Reset = 1'b1;
        clear_inputs();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("rst_busy", b1.Busy, 32'd0);
        chk("rst_grant", b1.GrantId, 32'd0);
        chk("rst_rsp0v", b1.Rsp0Valid, 32'd0);
        chk("rst_rsp1v", b1.Rsp1Valid, 32'd0);
        chk("rst_result", b1.RspResult, 32'd0);
        chk("rst_zero", b1.RspZero, 32'd0);
        chk("rst_alua", b1.AluA, 32'd0);
        chk("rst_aluop", b1.AluOp, 32'd0);
        chk("rst4_busy", b4.Busy, 32'd0);
        Reset = 1'b0;

        // Table of single operations, all opcodes and both SrcB selections.
        for (int i = 0; i < 10; i++) begin
            run_vec1(i, vecs[i]);
        end

        // Contention from reset: grants alternate 0,1,0,1 every 3 cycles.
        do_reset();
        @(negedge CLK);
        b1.Req0Valid = 1'b1; b1.Req0A = 32'd1;  b1.Req0B = 32'd1; b1.Req0Op = 3'b000; b1.Req0SrcB = 1'b0;
        b1.Req1Valid = 1'b1; b1.Req1A = 32'd10; b1.Req1Imm = 32'd4; b1.Req1Op = 3'b001; b1.Req1SrcB = 1'b1;
        n_acc = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            if (b1.Req0Ready && b1.Req1Ready) chk("cont_two_ready", 32'd1, 32'd0);
            if (b1.Rsp0Valid || b1.Rsp1Valid) begin
                sb_pop("cont", b1.Rsp1Valid, b1.RspResult, b1.RspZero);
            end
            if (b1.Req0Ready || b1.Req1Ready) begin
                g = b1.Req1Ready;
                chk($sformatf("cont_grant%0d", n_acc), g, n_acc % 2);
                chk($sformatf("cont_spacing%0d", n_acc), cyc, 3 * n_acc);
                if (g) sb.push_back('{1'b1, 32'd6, 1'b0});
                else   sb.push_back('{1'b0, 32'd2, 1'b0});
                n_acc++;
            end
            @(negedge CLK);
        end
        b1.Req0Valid = 1'b0; b1.Req1Valid = 1'b0;
        chk("cont_accepts", n_acc, 32'd4);
        chk("cont_sb_drained", sb.size(), 32'd0);

        // Response backpressure on port 0 while port 1 waits.
        do_reset();
        @(negedge CLK);
        b1.Req0Valid = 1'b1; b1.Req0A = 32'h100; b1.Req0B = 32'h23; b1.Req0Op = 3'b000; b1.Req0SrcB = 1'b0;
        b1.Rsp0Ready = 1'b0; b1.Rsp1Ready = 1'b1;
        #1 chk("bp_req0_ready", b1.Req0Ready, 32'd1);
        @(posedge CLK); #1;
        b1.Req0Valid = 1'b0;
        b1.Req1Valid = 1'b1; b1.Req1A = 32'hF; b1.Req1B = 32'h3; b1.Req1Op = 3'b110; b1.Req1SrcB = 1'b0;
        edges = 0;
        while (!b1.Rsp0Valid && edges < 20) begin
            @(posedge CLK); #1; edges++;
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_rsp0v_%0d", i), b1.Rsp0Valid, 32'd1);
            chk($sformatf("bp_result_%0d", i), b1.RspResult, 32'h123);
            chk($sformatf("bp_busy_%0d", i), b1.Busy, 32'd1);
            chk($sformatf("bp_req1_ready_%0d", i), b1.Req1Ready, 32'd0);
            @(posedge CLK); #1;
        end
        b1.Rsp0Ready = 1'b1;
        chk("bp_req1_ready_hs", b1.Req1Ready, 32'd0);
        @(posedge CLK); #1;
        chk("bp_rsp0v_drop", b1.Rsp0Valid, 32'd0);
        chk("bp_req1_granted", b1.Req1Ready, 32'd1);
        @(posedge CLK); #1;
        b1.Req1Valid = 1'b0;
        chk("bp_grant1", b1.GrantId, 32'd1);
        edges = 0;
        while (!b1.Rsp1Valid && edges < 20) begin
            @(posedge CLK); #1; edges++;
        end
        chk("bp_rsp1_result", b1.RspResult, 32'h0000000C);
        chk("bp_rsp1_latency", edges, 32'd1);
        @(posedge CLK); #1;

        // LATENCY=4: operands held stable, result sampled on the 4th edge.
        @(negedge CLK);
        b4.Req0Valid = 1'b1; b4.Req0A = 32'hFFFFFFFF; b4.Req0B = 32'h0000FFFF;
        b4.Req0Op = 3'b100; b4.Req0SrcB = 1'b0;
        #1 chk("l4_req0_ready", b4.Req0Ready, 32'd1);
        @(posedge CLK); #1;
        b4.Req0Valid = 1'b0; b4.Req0A = 32'h5A5A5A5A; b4.Req0B = 32'h0;
        edges = 0;
        while (!b4.Rsp0Valid && edges < 20) begin
            chk($sformatf("l4_alua_%0d", edges), b4.AluA, 32'hFFFFFFFF);
            chk($sformatf("l4_alub_%0d", edges), b4.AluB, 32'h0000FFFF);
            @(posedge CLK); #1; edges++;
        end
        chk("l4_latency", edges, 32'd4);
        chk("l4_result", b4.RspResult, 32'h0000FFFF);
        chk("l4_zero", b4.RspZero, 32'd0);
        @(posedge CLK); #1;
        chk("l4_idle", b4.Busy, 32'd0);

        // Reset mid-EXEC after port 0 last won: op dropped, port 0 wins next tie.
        b4.Req1Valid = 1'b1; b4.Req1A = 32'd2; b4.Req1B = 32'd2; b4.Req1Op = 3'b000;
        #1 chk("rx_req1_ready", b4.Req1Ready, 32'd1);
        @(posedge CLK); #1;
        b4.Req1Valid = 1'b0;
        @(posedge CLK); #1;
        chk("rx_busy_exec", b4.Busy, 32'd1);
        Reset = 1'b1;
        @(posedge CLK); #1;
        Reset = 1'b0;
        chk("rx_busy", b4.Busy, 32'd0);
        chk("rx_grant", b4.GrantId, 32'd0);
        chk("rx_alua", b4.AluA, 32'd0);
        chk("rx_result", b4.RspResult, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (b4.Rsp0Valid || b4.Rsp1Valid) seen = 1'b1;
            @(posedge CLK); #1;
        end
        chk("rx_no_rsp", seen, 32'd0);
        b4.Req0Valid = 1'b1; b4.Req0A = 32'h30; b4.Req0B = 32'h0C; b4.Req0Op = 3'b010; b4.Req0SrcB = 1'b0;
        b4.Req1Valid = 1'b1;
        #1;
        chk("rx_tie_req0", b4.Req0Ready, 32'd1);
        chk("rx_tie_req1", b4.Req1Ready, 32'd0);
        @(posedge CLK); #1;
        b4.Req0Valid = 1'b0; b4.Req1Valid = 1'b0;
        edges = 0;
        while (!b4.Rsp0Valid && edges < 20) begin
            @(posedge CLK); #1; edges++;
        end
        chk("rx_latency", edges, 32'd4);
        chk("rx_rsp_result", b4.RspResult, 32'hFFFFFFDC);
        @(posedge CLK); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end
endmodule
